wb_master: RTL and testbench

//  Pipelined Wishbone B4 initiator: turns a valid/ready command stream into
//  bus requests and returns one response per request. Counterpart of wb_mem
//  and other wb_* slaves; sits between a client (test driver, DMA, CPU shim)
//  and the bus. Handles stall back-pressure and multiple outstanding requests.

---
 rtl/wb_master_pkg.sv | 15 +
 rtl/wb_master_timeout.sv | 28 ++
 rtl/wb_master.sv | 164 ++++++++++++++++
 tb/tb_wb_master.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_master_pkg.sv
// wb_master_pkg: shared state type and sizing helper for the wb_master Wishbone initiator.
package wb_master_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    ABORT = 2'd2
  } state_t;

  // Width of a counter that must hold 0..max_outstanding inclusive.
  function automatic int f_cnt_width(input int max_outstanding);
    return $clog2(max_outstanding + 1);
  endfunction

endpackage

// File: rtl/wb_master_timeout.sv
// wb_master_timeout: ack watchdog for wb_master; fires once after G_TIMEOUT cycles without bus progress.
module wb_master_timeout #(
  parameter int G_TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic reload,
  output logic expired
);

  localparam int TW = $clog2(G_TIMEOUT + 1);

  logic [TW-1:0] count;

  assign expired = run && !reload && (count == TW'(G_TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (!run || reload || expired) begin
      count <= '0;
    end else begin
      count <= count + TW'(1);
    end
  end

endmodule

// File: rtl/wb_master.sv
// wb_master: pipelined Wishbone B4 initiator turning a valid/ready command stream into bus requests.
// Optional ack watchdog (and the ABORT path / err_o pulse) is built when WB_MASTER_TIMEOUT_EN is defined.
module wb_master
  import wb_master_pkg::*;
#(
  parameter int G_ADDR_SIZE       = 8,
  parameter int G_DATA_SIZE       = 16,
  parameter int G_MAX_OUTSTANDING = 4,
  parameter int G_TIMEOUT         = 64
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   s_valid_i,
  output logic                   s_ready_o,
  input  logic                   s_we_i,
  input  logic [G_ADDR_SIZE-1:0] s_addr_i,
  input  logic [G_DATA_SIZE-1:0] s_data_i,
  output logic                   m_valid_o,
  output logic                   m_we_o,
  output logic [G_DATA_SIZE-1:0] m_data_o,
  output logic                   err_o,
  output logic                   wb_cyc_o,
  output logic                   wb_stb_o,
  input  logic                   wb_stall_i,
  output logic                   wb_we_o,
  output logic [G_ADDR_SIZE-1:0] wb_addr_o,
  output logic [G_DATA_SIZE-1:0] wb_data_o,
  input  logic                   wb_ack_i,
  input  logic [G_DATA_SIZE-1:0] wb_data_i
);

  localparam int CW = f_cnt_width(G_MAX_OUTSTANDING);

  state_t                       state;
  logic [CW-1:0]                cnt;
  logic                         stb;
  logic                         issue_we;
  logic [G_ADDR_SIZE-1:0]       issue_addr;
  logic [G_DATA_SIZE-1:0]       issue_data;
  logic                         resp_valid;
  logic                         resp_we;
  logic [G_DATA_SIZE-1:0]       resp_data;
  logic [G_MAX_OUTSTANDING-1:0] dir_q;
  logic [G_MAX_OUTSTANDING-1:0] dir_next;
  logic [CW-1:0]                push_idx;
  logic                         accept;
  logic                         transfer;
  logic                         ack_ok;
  logic                         timeout;

  assign wb_cyc_o  = (state == BUSY);
  assign wb_stb_o  = stb;
  assign wb_we_o   = issue_we;
  assign wb_addr_o = issue_addr;
  assign wb_data_o = issue_data;
  assign m_valid_o = resp_valid;
  assign m_we_o    = resp_we;
  assign m_data_o  = resp_data;

  // Held low in reset so every output reads 0; also refused in the cycle the watchdog fires.
  assign s_ready_o = rst_ni && (!stb || !wb_stall_i)
                   && ((int'(cnt) + int'(stb)) < G_MAX_OUTSTANDING)
                   && (state != ABORT) && !timeout;

  assign accept   = s_valid_i && s_ready_o;
  assign transfer = stb && !wb_stall_i;
  assign ack_ok   = wb_ack_i && wb_cyc_o && (cnt != '0);

`ifdef WB_MASTER_TIMEOUT_EN
  logic err_q;
  logic wd_run;
  logic wd_reload;

  assign wd_run    = (cnt != '0) || stb;
  assign wd_reload = transfer || ack_ok;

  wb_master_timeout #(
    .G_TIMEOUT (G_TIMEOUT)
  ) u_timeout (
    .clk     (clk_i),
    .rst_n   (rst_ni),
    .run     (wd_run),
    .reload  (wd_reload),
    .expired (timeout)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) err_q <= 1'b0;
    else         err_q <= timeout;
  end

  assign err_o = err_q;
`else
  assign timeout = 1'b0;
  assign err_o   = 1'b0;
`endif

  // Direction FIFO: bit 0 is the oldest in-flight request; fill level equals cnt.
  always_comb begin
    // NOTE: every always_comb target gets a default first so no path can infer a latch.
    dir_next = dir_q;
    push_idx = ack_ok ? (cnt - CW'(1)) : cnt;
    if (ack_ok) begin
      dir_next = dir_q >> 1;
    end
    if (transfer) begin
      for (int i = 0; i < G_MAX_OUTSTANDING; i++) begin
        if (CW'(i) == push_idx) dir_next[i] = issue_we;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      state      <= IDLE;
      stb        <= 1'b0;
      issue_we   <= 1'b0;
      issue_addr <= '0;
      issue_data <= '0;
      cnt        <= '0;
      dir_q      <= '0;
      resp_valid <= 1'b0;
      resp_we    <= 1'b0;
      resp_data  <= '0;
    end else if (timeout) begin
      state      <= ABORT;
      stb        <= 1'b0;
      cnt        <= '0;
      dir_q      <= '0;
      resp_valid <= 1'b0;
      resp_we    <= 1'b0;
      resp_data  <= '0;
    end else begin
      case (state)
        IDLE:    if (accept) state <= BUSY;
        BUSY:    if ((cnt == '0) && !stb && !accept) state <= IDLE;
        ABORT:   state <= IDLE;
        default: state <= IDLE;
      endcase

      if (accept) begin
        stb        <= 1'b1;
        issue_we   <= s_we_i;
        issue_addr <= s_addr_i;
        issue_data <= s_data_i;
      end else if (transfer) begin
        stb <= 1'b0;
      end

      case ({transfer, ack_ok})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase

      dir_q      <= dir_next;
      resp_valid <= ack_ok;
      resp_we    <= ack_ok && dir_q[0];
      resp_data  <= (ack_ok && !dir_q[0]) ? wb_data_i : '0;
    end
  end

endmodule

// File: tb/tb_wb_master.sv
// tb_wb_master: directed + randomized bench for wb_master against a behavioural Wishbone memory slave
// and an in-order reference model of the expected response stream.
`timescale 1ns/1ps
module tb_wb_master;

  localparam int AW   = 8;
  localparam int DW   = 16;
  localparam int MAXO = 4;
  localparam int TMO  = 64;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          s_valid_i, s_ready_o, s_we_i;
  logic [AW-1:0] s_addr_i;
  logic [DW-1:0] s_data_i;
  logic          m_valid_o, m_we_o, err_o;
  logic [DW-1:0] m_data_o;
  logic          wb_cyc_o, wb_stb_o, wb_stall_i, wb_we_o, wb_ack_i;
  logic [AW-1:0] wb_addr_o;
  logic [DW-1:0] wb_data_o, wb_data_i;

  always #5 clk_i = ~clk_i;

  wb_master #(
    .G_ADDR_SIZE       (AW),
    .G_DATA_SIZE       (DW),
    .G_MAX_OUTSTANDING (MAXO),
    .G_TIMEOUT         (TMO)
  ) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .s_valid_i  (s_valid_i),
    .s_ready_o  (s_ready_o),
    .s_we_i     (s_we_i),
    .s_addr_i   (s_addr_i),
    .s_data_i   (s_data_i),
    .m_valid_o  (m_valid_o),
    .m_we_o     (m_we_o),
    .m_data_o   (m_data_o),
    .err_o      (err_o),
    .wb_cyc_o   (wb_cyc_o),
    .wb_stb_o   (wb_stb_o),
    .wb_stall_i (wb_stall_i),
    .wb_we_o    (wb_we_o),
    .wb_addr_o  (wb_addr_o),
    .wb_data_o  (wb_data_o),
    .wb_ack_i   (wb_ack_i),
    .wb_data_i  (wb_data_i)
  );

  typedef struct packed { logic we; logic [DW-1:0] data; } resp_t;
  typedef struct packed { int due; logic [DW-1:0] rdata; } pend_t;

  int vectors = 0;
  int miscompares = 0;
  int cyc_no = 0;

  logic [DW-1:0] slave_mem [256];
  logic [DW-1:0] ref_mem   [256];
  resp_t exp_q[$];
  pend_t pend_q[$];

  // Slave behaviour knobs
  int lat_min = 1, lat_max = 1, stall_pct = 0, force_stall = 0, last_due = 0;
  bit mute = 1'b0, spurious = 1'b0;

  // Observations
  bit            accepted, prev_stalled, track;
  int            outstanding = 0, xfers = 0, stb_cycles = 0;
  int            last_xfer_cyc = 0, last_ack_cyc = 0, err_seen = 0, err_cyc = 0;
  int            out_min, out_max;
  logic          last_ready, prev_we;
  logic [AW-1:0] last_addr, prev_addr;
  logic [DW-1:0] prev_data, last_rd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc_no);
    end
  endtask

  task automatic init_mems();
    for (int i = 0; i < 256; i++) begin
      slave_mem[i] = DW'((i * 257) ^ 16'h5A5A);
      ref_mem[i]   = DW'((i * 257) ^ 16'h5A5A);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ctl"}, {25'd0, s_ready_o, m_valid_o, m_we_o, err_o, wb_cyc_o, wb_stb_o, wb_we_o}, 32'd0);
    chk({tag, "_addr"}, 32'(wb_addr_o), 32'd0);
    chk({tag, "_wdata"}, 32'(wb_data_o), 32'd0);
    chk({tag, "_rdata"}, 32'(m_data_o), 32'd0);
  endtask

  // One clock cycle: slave drives, models update from pre-edge view, responses checked after the edge.
  task automatic cycle();
    bit            xfer, ack_real;
    int            due;
    logic [DW-1:0] rd;
    resp_t         e;
    wb_ack_i  = 1'b0;
    wb_data_i = DW'($urandom);
    if (spurious) begin
      wb_ack_i = 1'b1;
      spurious = 1'b0;
    end else if (!mute && pend_q.size() > 0 && pend_q[0].due <= cyc_no) begin
      wb_ack_i  = 1'b1;
      wb_data_i = pend_q[0].rdata;
    end
    if (force_stall > 0) begin
      wb_stall_i = 1'b1;
      force_stall--;
    end else begin
      wb_stall_i = ($urandom_range(99) < 32'(stall_pct));
    end
    #1;
    accepted   = s_valid_i && s_ready_o;
    last_ready = s_ready_o;
    last_addr  = wb_addr_o;
    xfer       = wb_cyc_o && wb_stb_o && !wb_stall_i;
    ack_real   = wb_ack_i && wb_cyc_o && (outstanding > 0);
    chk("stb_without_cyc", {31'd0, wb_stb_o && !wb_cyc_o}, 32'd0);
    if (prev_stalled) begin
      chk("stall_stb_held", {31'd0, wb_stb_o}, 32'd1);
      chk("stall_addr_held", 32'(wb_addr_o), 32'(prev_addr));
      chk("stall_we_held", {31'd0, wb_we_o}, {31'd0, prev_we});
      chk("stall_data_held", 32'(wb_data_o), 32'(prev_data));
    end
    prev_stalled = wb_stb_o && wb_stall_i;
    prev_addr    = wb_addr_o;
    prev_we      = wb_we_o;
    prev_data    = wb_data_o;
    if (wb_stb_o) stb_cycles++;
    if (accepted) begin
      exp_q.push_back('{we: s_we_i, data: s_we_i ? '0 : ref_mem[s_addr_i]});
      if (s_we_i) ref_mem[s_addr_i] = s_data_i;
    end
    if (xfer) begin
      xfers++;
      last_xfer_cyc = cyc_no;
      rd = slave_mem[wb_addr_o];
      if (wb_we_o) begin
        slave_mem[wb_addr_o] = wb_data_o;
        rd = DW'($urandom);
      end
      due = cyc_no + int'($urandom_range(lat_max, lat_min));
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      pend_q.push_back('{due: due, rdata: rd});
    end
    if (ack_real) begin
      last_ack_cyc = cyc_no;
      void'(pend_q.pop_front());
    end
    outstanding = outstanding + int'(xfer) - int'(ack_real);
    chk("outstanding_le_max", {31'd0, outstanding <= MAXO}, 32'd1);
    if (track) begin
      if (outstanding < out_min) out_min = outstanding;
      if (outstanding > out_max) out_max = outstanding;
    end
    @(posedge clk_i);
    cyc_no++;
    #1;
    if (m_valid_o) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_resp", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("resp_we", {31'd0, m_we_o}, {31'd0, e.we});
        chk("resp_data", 32'(m_data_o), 32'(e.data));
        if (!e.we) last_rd = m_data_o;
      end
    end
    if (err_o) begin
      err_seen++;
      err_cyc = cyc_no;
      exp_q.delete();
      pend_q.delete();
      outstanding = 0;
    end
  endtask

  task automatic send(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int n;
    n = 0;
    s_valid_i = 1'b1;
    s_we_i    = we;
    s_addr_i  = a;
    s_data_i  = d;
    accepted  = 1'b0;
    while (!accepted && n < 200) begin
      cycle();
      n++;
    end
    chk("send_accepted", {31'd0, accepted}, 32'd1);
    s_valid_i = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() > 0 || wb_cyc_o) && n < 400) begin
      cycle();
      n++;
    end
    chk("drain_done", {31'd0, exp_q.size() == 0 && !wb_cyc_o}, 32'd1);
  endtask

  initial begin
    int x0, n;
    s_valid_i = 1'b0; s_we_i = 1'b0; s_addr_i = '0; s_data_i = '0;
    wb_stall_i = 1'b0; wb_ack_i = 1'b0; wb_data_i = '0;
    init_mems();

    // Reset state
    #12;
    chk_zero("reset");
    rst_ni = 1'b1;

    // 1: write then read the same address
    send(1'b1, 8'h12, 16'hBEEF);
    send(1'b0, 8'h12, 16'h0000);
    drain();
    chk("t1_read_data", 32'(last_rd), 32'h0000BEEF);

    // 2: eight back-to-back reads, no stall, single-cycle slave
    stb_cycles = 0;
    x0 = xfers;
    for (int i = 0; i < 8; i++) send(1'b0, AW'(i * 3), '0);
    drain();
    chk("t2_stb_cycles", 32'(stb_cycles), 32'd8);
    chk("t2_xfers", 32'(xfers - x0), 32'd8);

    // 3: stall held three cycles on the second request
    x0 = xfers;
    send(1'b0, 8'h40, '0);
    send(1'b0, 8'h41, '0);
    force_stall = 3;
    s_valid_i = 1'b1; s_we_i = 1'b0; s_addr_i = 8'h42;
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("t3_ready_low", {31'd0, last_ready}, 32'd0);
      chk("t3_addr_stable", 32'(last_addr), 32'h41);
    end
    send(1'b0, 8'h42, '0);
    drain();
    chk("t3_xfers", 32'(xfers - x0), 32'd3);

    // 4: transfer and ack in the same cycle, then cyc release timing
    out_min = 99; out_max = -1;
    for (int i = 0; i < 12; i++) begin
      track = (i >= 2);
      send(1'b1, AW'(8'h80 + i), DW'($urandom));
    end
    track = 1'b0;
    chk("t4_cnt_constant", 32'(out_max - out_min), 32'd0);
    n = 0;
    while (wb_cyc_o && n < 50) begin
      cycle();
      n++;
    end
    chk("t4_cyc_fall", 32'(cyc_no - last_ack_cyc), 32'd2);
    chk("t4_queue_empty", 32'(exp_q.size()), 32'd0);

    // 5: spurious ack while idle
    spurious = 1'b1;
    cycle();
    chk("t5_no_resp", {31'd0, m_valid_o}, 32'd0);
    chk("t5_idle", {31'd0, wb_cyc_o}, 32'd0);

    // Randomized traffic: random stalls, slave latency 1..4, narrow address range
    lat_min = 1; lat_max = 4; stall_pct = 25;
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(9) < 3) cycle();
      send(1'($urandom_range(1)), AW'($urandom_range(15)), DW'($urandom));
    end
    drain();
    lat_min = 1; lat_max = 1; stall_pct = 0;

    // 6: slave never acks
    mute = 1'b1;
    err_seen = 0;
`ifdef WB_MASTER_TIMEOUT_EN
    send(1'b0, 8'h20, '0);
    send(1'b0, 8'h21, '0);
    n = 0;
    while (err_seen == 0 && n < 200) begin
      cycle();
      n++;
    end
    chk("t6_err_seen", 32'(err_seen), 32'd1);
    chk("t6_err_delay", {31'd0, (err_cyc - last_xfer_cyc) inside {[TMO:TMO+2]}}, 32'd1);
    chk("t6_cyc_low", {30'd0, wb_cyc_o, wb_stb_o}, 32'd0);
    cycle();
    chk("t6_err_one_cycle", {31'd0, err_o}, 32'd0);
    mute = 1'b0;
    send(1'b0, 8'h12, '0);
    drain();
    chk("t6_recovered", 32'(last_rd), 32'h0000BEEF);
`else
    send(1'b0, 8'h20, '0);
    for (int k = 0; k < 150; k++) cycle();
    chk("t6_cyc_waits", {31'd0, wb_cyc_o}, 32'd1);
    chk("t6_no_err", 32'(err_seen), 32'd0);
`endif
    mute = 1'b0;

    // Reset asserted mid-burst
    lat_min = 2; lat_max = 2;
    send(1'b1, 8'h30, 16'h1111);
    send(1'b1, 8'h31, 16'h2222);
    send(1'b0, 8'h30, '0);
    cycle();
    #2 rst_ni = 1'b0;
    #1 chk_zero("rst_async");
    exp_q.delete(); pend_q.delete(); outstanding = 0; prev_stalled = 1'b0;
    init_mems();
    @(posedge clk_i);
    #1 chk_zero("rst_held");
    rst_ni = 1'b1;
    lat_min = 1; lat_max = 1;
    send(1'b1, 8'h05, 16'h1234);
    send(1'b0, 8'h05, '0);
    drain();
    chk("post_reset_read", 32'(last_rd), 32'h00001234);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: observed no end of test, expected completion");
    $fatal(1, "simulation time limit");
  end

endmodule
